key_matrix_scan: RTL and testbench
==================================

Name: key_matrix_scan

Overview:
- 4x4 matrix keypad scanner for the calculator front end; the input-side counterpart to the seven-segment display driver.
- Drives keypad rows and reads columns, then debounces press and release.
- Emits a one-cycle valid strobe with a 4-bit key code for the calculator control logic.
- Runs off the 50 MHz system clock with an internal scan-tick divider.

Parameters:
- SCAN_DIV, 50000: system clocks per scan tick (1 ms at 50 MHz); must be ≥2.
- DEB_TICKS, 20: consecutive stable ticks required to accept a press or release; must be ≥1.

Ports:
- Clk  input  1  system clock, 50 MHz
- Rst_n  input  1  asynchronous reset, active low
- En  input  1  enable, active high; low forces idle, rows released, no events
- key_col  input  4  column sense lines, active low (external pull-ups); asynchronous to Clk
- key_row  output  4  row drive lines, active low (1 = not driving)
- key_code  output  4  code of last accepted key: {row_index[1:0], col_index[1:0]}
- key_valid  output  1  one-Clk-cycle pulse when a new key is accepted
- key_down  output  1  high from acceptance until release is debounced

Behaviour:
- Interface: one clock, Clk; reset is asynchronous and active-low, Rst_n.
- Reset values: key_row=4'b1111, key_code=4'h0, key_valid=0, key_down=0, state=IDLE, all counters 0.
- Column sync: key_col passes through a 2-flop synchronizer (reset to 4'b1111); all decisions use the synchronized value col_s. "Any pressed" means col_s != 4'b1111.
- Tick divider: counts 0..SCAN_DIV-1 while En=1 and wraps. tick is a 1-cycle pulse at count SCAN_DIV-1. All FSM transitions except En/reset occur only on tick cycles.
- Registered outputs: every FSM output is registered and takes its new value the Clk cycle after the transition.
- IDLE:
  - key_row=4'b0000 (all rows driven) while En=1.
  - On tick with any pressed -> DEBOUNCE, deb_cnt=1.
- DEBOUNCE:
  - key_row=4'b0000.
  - On tick: if all columns released -> IDLE.
  - Else if deb_cnt==DEB_TICKS -> SCAN with row_idx=0.
  - Else deb_cnt++.
- SCAN:
  - key_row = row_idx one-cold (row 0 -> 4'b1110, row 1 -> 4'b1101, ...). The row is driven for a full tick before sampling.
  - On tick with any pressed: latch key_code={row_idx, c}, where c is the lowest index with col_s[c]=0, then -> PRESSED.
  - Else if row_idx==3 -> IDLE (bounce or release during scan; no event).
  - Else row_idx++.
- PRESSED:
  - Lasts exactly one Clk cycle (not tick-qualified).
  - key_valid=1 for that cycle; key_down set to 1.
  - -> RELEASE with rel_cnt=0; key_row returns to 4'b0000.
- RELEASE:
  - On tick: if any pressed -> rel_cnt=0.
  - Else if rel_cnt==DEB_TICKS-1 -> IDLE with key_down=0.
  - Else rel_cnt++.
- Multiple simultaneous keys: the lowest row, then the lowest column, wins. Exactly one event per press/release cycle. Extra keys pressed while in RELEASE produce no event until all keys are released and debounced.
- key_code holds its last value until the next accepted key. This persists through En low; only reset clears it.
- En=0:
  - Synchronous: next cycle state=IDLE, divider and counters cleared, key_row=4'b1111, key_valid=0, key_down=0.
  - Re-asserting En restarts from IDLE with a fresh divider.
- Reset mid-operation: all outputs return to reset values immediately and asynchronously. A pending event is discarded.
- Press latency: accepted key_valid occurs within 2 sync cycles + (DEB_TICKS+1+row_index+1) ticks of a clean press.

Test Plan (SCAN_DIV=10, DEB_TICKS=3):
- Reset then En=1, no keys -> key_row=4'b0000 after first cycle; key_valid never asserts over 1000 cycles; key_down=0.
- Clean press of row 2/col 1 (key_col[1]=0 only while key_row[2]=0) held 200 cycles -> exactly one key_valid pulse; key_code=4'h9; key_down=1. After release, key_down falls 3 ticks (30 cycles ±10) after col_s returns to 4'b1111.
- Glitch: col low for 15 cycles, then high -> no key_valid; FSM returns to IDLE.
- Two keys at row 1/col 3 and row 1/col 0 -> key_code=4'h4. Then press row 3/col 3 while still holding -> no second pulse until full release and a new press.
- En dropped mid-SCAN -> next cycle key_row=4'b1111 and key_down=0; key_code is unchanged.
- Rst_n asserted during RELEASE -> key_row=4'b1111, key_code=0, key_down=0 immediately, without waiting for a Clk edge.

Source files
------------

// File: rtl/key_matrix_scan_if.sv
// Keypad-side and event-side signals of the 4x4 matrix scanner.
// The master modport is the scanner; the slave modport is the keypad/consumer side.
interface key_matrix_scan_if;
    logic [3:0] key_col;
    logic [3:0] key_row;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;

    modport master (
        input  key_col,
        output key_row,
        output key_code,
        output key_valid,
        output key_down
    );

    modport slave (
        output key_col,
        input  key_row,
        input  key_code,
        input  key_valid,
        input  key_down
    );
endinterface

// File: rtl/key_matrix_scan.sv
// 4x4 keypad scanner: all-rows press detect, tick-based debounce, row scan,
// one-cycle key event and release debounce.
module key_matrix_scan #(
    parameter int SCAN_DIV  = 50000,
    parameter int DEB_TICKS = 20
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               En,
    key_matrix_scan_if.master  kp
);
    localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEB_TICKS + 1);

    typedef enum logic [2:0] {IDLE, DEBOUNCE, SCAN, PRESSED, RELEASE} state_t;

    state_t        state, state_n;
    logic [3:0]    col_m, col_s;
    logic [DW-1:0] div_cnt;
    logic          tick;
    logic [CW-1:0] deb_cnt, deb_n, rel_cnt, rel_n;
    logic [1:0]    row_idx, row_idx_n, low_col;
    logic [3:0]    key_row_q, row_n, key_code_q, code_n;
    logic          key_valid_q, valid_n, key_down_q, down_n;
    logic          any_pressed;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            col_m <= 4'b1111;
            col_s <= 4'b1111;
        end else begin
            col_m <= kp.key_col;
            col_s <= col_m;
        end
    end

    assign any_pressed = (col_s != 4'b1111);
    assign tick        = En && (div_cnt == DW'(SCAN_DIV - 1));

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)            div_cnt <= '0;
        else if (!En || tick)  div_cnt <= '0;
        else                   div_cnt <= div_cnt + DW'(1);
    end

    // Lowest active column wins when several columns read low on the driven row.
    always_comb begin
        low_col = 2'd3;
        if (!col_s[0])      low_col = 2'd0;
        else if (!col_s[1]) low_col = 2'd1;
        else if (!col_s[2]) low_col = 2'd2;
    end

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_n   = state;
        deb_n     = deb_cnt;
        rel_n     = rel_cnt;
        row_idx_n = row_idx;
        code_n    = key_code_q;
        if (!En) begin
            state_n   = IDLE;
            deb_n     = '0;
            rel_n     = '0;
            row_idx_n = 2'd0;
        end else begin
            case (state)
                IDLE: if (tick && any_pressed) begin
                    state_n = DEBOUNCE;
                    deb_n   = CW'(1);
                end
                DEBOUNCE: if (tick) begin
                    if (!any_pressed)                  state_n = IDLE;
                    else if (deb_cnt == CW'(DEB_TICKS)) begin
                        state_n   = SCAN;
                        row_idx_n = 2'd0;
                    end else                           deb_n = deb_cnt + CW'(1);
                end
                SCAN: if (tick) begin
                    if (any_pressed) begin
                        code_n  = {row_idx, low_col};
                        state_n = PRESSED;
                    end else if (row_idx == 2'd3)      state_n = IDLE;
                    else                               row_idx_n = row_idx + 2'd1;
                end
                PRESSED: begin
                    state_n = RELEASE;
                    rel_n   = '0;
                end
                RELEASE: if (tick) begin
                    if (any_pressed)                       rel_n = '0;
                    else if (rel_cnt == CW'(DEB_TICKS - 1)) state_n = IDLE;
                    else                                   rel_n = rel_cnt + CW'(1);
                end
                default: state_n = IDLE;
            endcase
        end

        // Outputs follow the next state so they register alongside it.
        if (!En)                                         row_n = 4'b1111;
        else if (state_n == SCAN || state_n == PRESSED)  row_n = ~(4'b0001 << row_idx_n);
        else                                             row_n = 4'b0000;
        valid_n = En && (state_n == PRESSED);
        down_n  = En && (state_n == PRESSED || state_n == RELEASE);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state       <= IDLE;
            deb_cnt     <= '0;
            rel_cnt     <= '0;
            row_idx     <= 2'd0;
            key_row_q   <= 4'b1111;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            state       <= state_n;
            deb_cnt     <= deb_n;
            rel_cnt     <= rel_n;
            row_idx     <= row_idx_n;
            key_row_q   <= row_n;
            key_code_q  <= code_n;
            key_valid_q <= valid_n;
            key_down_q  <= down_n;
        end
    end

    assign kp.key_row   = key_row_q;
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_down  = key_down_q;
endmodule

// File: tb/tb_key_matrix_scan.sv
// Bench for key_matrix_scan: a keypad model closes row/column contacts, a scoreboard
// holds the expected key code per press and a monitor checks each key_valid strobe.
module tb_key_matrix_scan;
    localparam int SCAN_DIV  = 10;
    localparam int DEB_TICKS = 3;

    logic Clk = 1'b0;
    logic Rst_n = 1'b1;
    logic En = 1'b0;
    logic [15:0] pressed = '0;
    logic [3:0]  kc;
    logic [3:0]  last_code = 4'h0;
    logic [3:0]  sb[$];
    int n_checks = 0;
    int n_pass   = 0;

    key_matrix_scan_if ifc ();

    key_matrix_scan #(.SCAN_DIV(SCAN_DIV), .DEB_TICKS(DEB_TICKS)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .En    (En),
        .kp    (ifc.master)
    );

    always #5 Clk = ~Clk;

    // Keypad: a closed key pulls its column low only while its row is driven low.
    always_comb begin
        kc = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4 + c] && !ifc.key_row[r]) kc[c] = 1'b0;
    end
    assign ifc.key_col = kc;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Reference: lowest row then lowest column == lowest key index r*4+c.
    function automatic logic [3:0] winner(input logic [15:0] keys);
        for (int i = 0; i < 16; i++)
            if (keys[i]) return 4'(i);
        return 4'h0;
    endfunction

    always @(negedge Clk) begin
        if (Rst_n && ifc.key_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", {31'd0, ifc.key_valid}, 32'd0);
            end else begin
                logic [3:0] e;
                e = sb.pop_front();
                check("key_code", {28'd0, ifc.key_code}, {28'd0, e});
                check("key_down_at_valid", {31'd0, ifc.key_down}, 32'd1);
            end
        end
    end

    task automatic wait_down(input logic lvl, input int bound, output int cyc);
        cyc = 0;
        while (ifc.key_down !== lvl && cyc < bound) begin
            @(negedge Clk);
            cyc++;
        end
    endtask

    task automatic expect_key(input logic [15:0] keys);
        sb.push_back(winner(keys));
        last_code = winner(keys);
    endtask

    task automatic press_cycle(input logic [15:0] keys, input int hold_extra);
        int cyc;
        expect_key(keys);
        pressed = keys;
        wait_down(1'b1, 200, cyc);
        check("down_rise", {31'd0, ifc.key_down}, 32'd1);
        repeat (hold_extra) @(negedge Clk);
        pressed = '0;
        wait_down(1'b0, 100, cyc);
        check("down_fall", {31'd0, ifc.key_down}, 32'd0);
        repeat (20) @(negedge Clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        #2 Rst_n = 1'b0;
        #20;
        check("rst_row",   {28'd0, ifc.key_row},  32'hF);
        check("rst_code",  {28'd0, ifc.key_code}, 32'h0);
        check("rst_valid", {31'd0, ifc.key_valid}, 32'd0);
        check("rst_down",  {31'd0, ifc.key_down}, 32'd0);
        @(negedge Clk) Rst_n = 1'b1;
        repeat (3) @(negedge Clk);
        check("disabled_row", {28'd0, ifc.key_row}, 32'hF);

        // Idle with no keys: rows driven, no events for 1000 cycles.
        En = 1'b1;
        @(posedge Clk); #1;
        check("idle_row", {28'd0, ifc.key_row}, 32'h0);
        repeat (1000) @(negedge Clk);
        check("idle_down", {31'd0, ifc.key_down}, 32'd0);

        // Clean press of row 2 / col 1, held 200 cycles, then release timing.
        expect_key(16'h0200);
        pressed = 16'h0200;
        repeat (200) @(negedge Clk);
        check("held_down", {31'd0, ifc.key_down}, 32'd1);
        check("held_code", {28'd0, ifc.key_code}, 32'h9);
        pressed = '0;
        wait_down(1'b0, 100, cyc);
        check("release_delay_ok", {31'd0, (cyc >= 20 && cyc <= 42)}, 32'd1);
        repeat (20) @(negedge Clk);

        // Short glitch never survives debounce.
        pressed = 16'h0001;
        repeat (15) @(negedge Clk);
        pressed = '0;
        repeat (100) @(negedge Clk);
        check("glitch_down", {31'd0, ifc.key_down}, 32'd0);
        check("glitch_idle_row", {28'd0, ifc.key_row}, 32'h0);

        // Two keys in row 1; a third key during RELEASE gives no second event.
        expect_key(16'h0090);
        pressed = 16'h0090;
        wait_down(1'b1, 200, cyc);
        check("multi_down", {31'd0, ifc.key_down}, 32'd1);
        pressed = 16'h8090;
        repeat (100) @(negedge Clk);
        check("multi_still_down", {31'd0, ifc.key_down}, 32'd1);
        check("multi_code", {28'd0, ifc.key_code}, 32'h4);
        pressed = '0;
        wait_down(1'b0, 100, cyc);
        check("multi_release", {31'd0, ifc.key_down}, 32'd0);
        repeat (20) @(negedge Clk);
        press_cycle(16'h8000, 10);

        // En dropped while scanning: rows released, code held.
        pressed = 16'h1000;
        cyc = 0;
        while (ifc.key_row !== 4'b1110 && cyc < 200) begin
            @(negedge Clk);
            cyc++;
        end
        check("scan_seen", {28'd0, ifc.key_row}, 32'hE);
        En = 1'b0;
        @(posedge Clk); #1;
        check("en_off_row",  {28'd0, ifc.key_row},  32'hF);
        check("en_off_down", {31'd0, ifc.key_down}, 32'd0);
        check("en_off_code", {28'd0, ifc.key_code}, {28'd0, last_code});
        @(negedge Clk);
        pressed = '0;
        repeat (5) @(negedge Clk);
        En = 1'b1;
        repeat (20) @(negedge Clk);

        // Asynchronous reset while in RELEASE.
        expect_key(16'h0020);
        pressed = 16'h0020;
        wait_down(1'b1, 200, cyc);
        check("pre_rst_down", {31'd0, ifc.key_down}, 32'd1);
        repeat (5) @(negedge Clk);
        #1 Rst_n = 1'b0;
        pressed = '0;
        #1;
        check("arst_row",  {28'd0, ifc.key_row},  32'hF);
        check("arst_code", {28'd0, ifc.key_code}, 32'h0);
        check("arst_down", {31'd0, ifc.key_down}, 32'd0);
        last_code = 4'h0;
        @(negedge Clk) Rst_n = 1'b1;
        repeat (20) @(negedge Clk);

        // Randomized presses of one or two keys.
        for (int i = 0; i < 10; i++) begin
            logic [15:0] keys;
            keys = 16'(1) << $urandom_range(15, 0);
            if ($urandom_range(1, 0) == 1) keys = keys | (16'(1) << $urandom_range(15, 0));
            press_cycle(keys, $urandom_range(40, 0));
        end

        repeat (50) @(negedge Clk);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
